gate_bist: RTL and testbench
============================

# gate_bist

Synthesizable exhaustive tester for small combinational logic gates. On `start` it walks every input pattern from 0 to 2^N_INPUTS-1 into the gate under test and samples the gate output after a programmable settle time. Each sample is compared against an internal golden model, and the block reports pass/fail, an error count and the first failing pattern. It sits beside a gate instance in the lecture designs and replaces the hand-written stimulus-and-print flow with an on-chip driver/checker.

## Interface
- N_INPUTS, 2, number of gate inputs; legal range 1..8
- SETTLE_CYCLES, 1, cycles each pattern is held before sampling; legal range ≥1
- clk  input  1  clock; all state updates on rising edge
- rstn  input  1  asynchronous active-low reset
- op  input  2  golden function, from `gate_op_e`: AND=0, OR=1, XOR=2, NAND=3; sampled on accepted `start`
- start  input  1  one-cycle request; accepted only in IDLE
- stim  output  N_INPUTS  pattern driven to the gate under test (bit 0 = x, bit 1 = y)
- dut_z  input  1  gate-under-test output
- busy  output  1  high from the cycle after an accepted `start` through the SAMPLE cycle of the last pattern
- done  output  1  one-cycle pulse when the sweep finishes
- pass  output  1  1 iff the last completed sweep had err_count == 0
- err_count  output  N_INPUTS+1  number of mismatching patterns in the current or last sweep
- first_fail  output  N_INPUTS  pattern of the first mismatch; valid when err_count != 0

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE, start=1:
  - latch `op`
  - clear err_count, first_fail and pass
  - set stim=0 and the settle counter to 0
  - go to DRIVE
- IDLE, start=0: hold all outputs.
- DRIVE: stim held; the counter increments each cycle. After SETTLE_CYCLES cycles in DRIVE, go to SAMPLE.
- SAMPLE: compare `dut_z` against golden(op_latched, stim).
  - On mismatch: increment err_count. If err_count was 0, also capture first_fail=stim.
  - If stim == 2^N_INPUTS-1: go to DONE.
  - Otherwise: stim+1, counter cleared, go to DRIVE.
- DONE, one cycle:
  - done=1
  - pass=(err_count==0), using the final count including the last SAMPLE
  - go to IDLE
- stim stays at its final value in IDLE until the next start.
- start outside IDLE is ignored, with no queueing.
- Comparison is 2-state. An X on dut_z gives an unspecified result and is not a requirement.
- err_count cannot overflow: its width holds 2^N_INPUTS.
- Golden model per op: AND = &stim, OR = |stim, XOR = ^stim, NAND = ~&stim.

## Timing
- Reset values:
  - state=IDLE, stim=0, busy=0, done=0, pass=0, err_count=0, first_fail=0
  - the latched op is AND
- Reset mid-sweep aborts immediately to the reset values. No done pulse is produced.
- Accepted start in cycle T: stim=0 and busy=1 from T+1.
- Each pattern occupies SETTLE_CYCLES+1 cycles: SETTLE_CYCLES in DRIVE, then 1 in SAMPLE.
- dut_z is registered-compared in the SAMPLE cycle, so the gate has at least SETTLE_CYCLES full cycles to settle.
- Sweep length is 2^N_INPUTS × (SETTLE_CYCLES+1) cycles of busy, followed by a 1-cycle done.
- With defaults: busy T+1..T+8, done at T+9, back in IDLE at T+10.
- pass, err_count and first_fail are stable from the done cycle until the next accepted start.
- start asserted in the done cycle is ignored. The earliest accepted restart is the cycle after done.

## Structure
- Package `gate_bist_pkg` holds:
  - `gate_op_e` (2-bit enum)
  - `bist_state_e` (IDLE/DRIVE/SAMPLE/DONE)
  - function `gate_golden(op, stim)` as the golden model, reused by the bench scoreboard
- No sub-module is needed. The FSM, settle counter, pattern register and error logic live in one module, `gate_bist`.
- The bench instantiates `gate_bist` connected to `and_gate` (stim[0]→x, stim[1]→y, z→dut_z). Fault cases use small inline stub gates.

## Test plan
- Defaults, op=AND, real and_gate, start at T → stim sequence 0,0,1,1,2,2,3,3 over T+1..T+8; done at T+9; pass=1; err_count=0.
- op=AND, dut_z tied 0 → err_count=1, first_fail=2'b11, pass=0.
- op=AND, dut_z tied 1 → err_count=3, first_fail=2'b00, pass=0.
- op=XOR, real and_gate → mismatches at patterns 1, 2 and 3; err_count=3, first_fail=2'b01.
- SETTLE_CYCLES=3, op=AND, real gate → busy for exactly 16 cycles, done at T+17, pass=1. In the same run, start pulsed mid-sweep and in the done cycle → no restart, counts unchanged.
- rstn pulsed low mid-sweep at pattern 2 → all outputs at reset values asynchronously, no done pulse. The next start runs a full clean sweep with pass=1.

Source files
------------

// File: rtl/gate_bist_pkg.sv
// Shared types and golden gate model for the exhaustive gate tester.
package gate_bist_pkg;

  localparam int unsigned MAX_INPUTS = 8;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_NAND = 2'd3
  } gate_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } bist_state_e;

  // Reference output for a pattern; bits at and above n_inputs are ignored.
  function automatic logic gate_golden(input gate_op_e                op,
                                       input logic [MAX_INPUTS-1:0] stim,
                                       input int unsigned           n_inputs);
    logic [MAX_INPUTS-1:0] mask;
    logic [MAX_INPUTS-1:0] v;
    logic                  all_ones;
    logic                  g;
    mask     = MAX_INPUTS'((9'd1 << n_inputs) - 9'd1);
    v        = stim & mask;
    all_ones = (v == mask);
    case (op)
      OP_AND:  g = all_ones;
      OP_OR:   g = |v;
      OP_XOR:  g = ^v;
      OP_NAND: g = ~all_ones;
      default: g = 1'b0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/and_gate.sv
// Two-input AND gate used as the lecture gate under test.
module and_gate (
  input  logic x,
  input  logic y,
  output logic z
);

  assign z = x & y;

endmodule

// File: rtl/gate_bist.sv
// Exhaustive driver/checker: sweeps all input patterns into a gate and
// compares each settled output against the golden model.
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter int unsigned N_INPUTS      = 2,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [1:0]          op,
  input  logic                start,
  output logic [N_INPUTS-1:0] stim,
  input  logic                dut_z,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_INPUTS:0]   err_count,
  output logic [N_INPUTS-1:0] first_fail
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  bist_state_e         state_q, state_d;
  gate_op_e            op_q, op_d;
  logic [N_INPUTS-1:0] stim_q, stim_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_INPUTS:0]   err_q, err_d;
  logic [N_INPUTS-1:0] ff_q, ff_d;
  logic                pass_q, pass_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                mismatch_c;

  assign mismatch_c = dut_z != gate_golden(op_q, MAX_INPUTS'(stim_q), N_INPUTS);

  // Next-state and result update
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    stim_d  = stim_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ff_d    = ff_q;
    pass_d  = pass_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = gate_op_e'(op);
          err_d   = '0;
          ff_d    = '0;
          pass_d  = 1'b0;
          stim_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        busy_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        if (mismatch_c) begin
          err_d = err_q + (N_INPUTS + 1)'(1);
          if (err_q == '0) begin
            ff_d = stim_q;
          end
        end
        if (&stim_q) begin
          // pass reflects the count including this final sample
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
          state_d = ST_DONE;
        end else begin
          stim_d  = stim_q + N_INPUTS'(1);
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_DRIVE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      op_q    <= OP_AND;
      stim_q  <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      ff_q    <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      stim_q  <= stim_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign stim       = stim_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_gate_bist.sv
// Self-checking bench for gate_bist: directed timing cases plus random
// op/fault truth tables checked against a pattern-level reference model.
module tb_gate_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic [1:0] op_a, op_b;
  logic       start_a, start_b;
  logic [1:0] stim_a, stim_b;
  logic       gate_z_a, gate_z_b, dut_z_a;
  logic       use_real;
  logic [3:0] tt;
  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [2:0] err_a, err_b;
  logic [1:0] ff_a, ff_b;

  int checks = 0;
  int errors = 0;

  // Gate under test for the default instance: real AND or a truth-table stub.
  and_gate u_and_a (.x(stim_a[0]), .y(stim_a[1]), .z(gate_z_a));
  assign dut_z_a = use_real ? gate_z_a : tt[stim_a];

  gate_bist #(.N_INPUTS(2), .SETTLE_CYCLES(1)) dut_a (
    .clk(clk), .rstn(rstn), .op(op_a), .start(start_a), .stim(stim_a),
    .dut_z(dut_z_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_fail(ff_a)
  );

  and_gate u_and_b (.x(stim_b[0]), .y(stim_b[1]), .z(gate_z_b));

  gate_bist #(.N_INPUTS(2), .SETTLE_CYCLES(3)) dut_b (
    .clk(clk), .rstn(rstn), .op(op_b), .start(start_b), .stim(stim_b),
    .dut_z(gate_z_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_fail(ff_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected gate output per op, straight from the truth of each function.
  function automatic bit ref_gate(input int op, input int p);
    case (op)
      0:       return p == 3;
      1:       return p != 0;
      2:       return ($countones(p) % 2) == 1;
      default: return p != 3;
    endcase
  endfunction

  task automatic model(input int op, input logic [3:0] table_in,
                       output int exp_err, output int exp_ff);
    exp_err = 0;
    exp_ff  = 0;
    for (int p = 0; p < 4; p++) begin
      if (table_in[p] != ref_gate(op, p)) begin
        if (exp_err == 0) exp_ff = p;
        exp_err++;
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Full sweep on the default instance with cycle-accurate checks.
  task automatic run_a(input int op, input bit real_g, input logic [3:0] tt_in, input string tag);
    int exp_err, exp_ff;
    logic [3:0] eff;
    op_a     = 2'(op);
    use_real = real_g;
    tt       = tt_in;
    eff      = real_g ? 4'b1000 : tt_in;
    model(op, eff, exp_err, exp_ff);
    start_a = 1'b1;
    next_cycle();
    start_a = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("%s busy c%0d", tag, k), 32'(busy_a), 32'(1));
      check($sformatf("%s stim c%0d", tag, k), 32'(stim_a), 32'((k - 1) / 2));
      check($sformatf("%s done c%0d", tag, k), 32'(done_a), 32'(0));
      next_cycle();
    end
    check({tag, " done"}, 32'(done_a), 32'(1));
    check({tag, " busy_end"}, 32'(busy_a), 32'(0));
    check({tag, " pass"}, 32'(pass_a), 32'(exp_err == 0));
    check({tag, " err"}, 32'(err_a), 32'(exp_err));
    check({tag, " first_fail"}, 32'(ff_a), 32'(exp_ff));
    next_cycle();
    check({tag, " done_low"}, 32'(done_a), 32'(0));
    check({tag, " stim_hold"}, 32'(stim_a), 32'(3));
    check({tag, " err_hold"}, 32'(err_a), 32'(exp_err));
    check({tag, " pass_hold"}, 32'(pass_a), 32'(exp_err == 0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_err, exp_ff, nbusy;
    rstn = 1'b0; start_a = 1'b0; start_b = 1'b0;
    op_a = 2'd0; op_b = 2'd0; use_real = 1'b1; tt = 4'h0;
    #1;
    check("rst stim", 32'(stim_a), 32'(0));
    check("rst busy", 32'(busy_a), 32'(0));
    check("rst done", 32'(done_a), 32'(0));
    check("rst pass", 32'(pass_a), 32'(0));
    check("rst err", 32'(err_a), 32'(0));
    check("rst ff", 32'(ff_a), 32'(0));
    next_cycle();
    next_cycle();
    rstn = 1'b1;
    next_cycle();
    check("idle hold", 32'(busy_a | done_a), 32'(0));

    // Directed cases
    run_a(0, 1'b1, 4'h0, "and_real");
    model(0, 4'h0, exp_err, exp_ff);
    check("tied0 model", 32'(exp_err), 32'(1));
    run_a(0, 1'b0, 4'h0, "and_tied0");
    check("tied0 ff", 32'(ff_a), 32'(3));
    run_a(0, 1'b0, 4'hF, "and_tied1");
    check("tied1 ff", 32'(ff_a), 32'(0));
    check("tied1 err", 32'(err_a), 32'(3));
    run_a(2, 1'b1, 4'h0, "xor_real");
    check("xor ff", 32'(ff_a), 32'(1));
    run_a(1, 1'b1, 4'h0, "or_real");
    run_a(3, 1'b1, 4'h0, "nand_real");

    // Long settle: stray starts mid-sweep and in the done cycle are ignored
    op_b = 2'd0;
    start_b = 1'b1;
    next_cycle();
    start_b = 1'b0;
    nbusy = 0;
    for (int k = 1; k <= 16; k++) begin
      if (busy_b) nbusy++;
      check($sformatf("settle3 stim c%0d", k), 32'(stim_b), 32'((k - 1) / 4));
      check($sformatf("settle3 done c%0d", k), 32'(done_b), 32'(0));
      start_b = (k == 6);
      if (k == 6) op_b = 2'd2;
      next_cycle();
    end
    start_b = 1'b0;
    check("settle3 busy count", 32'(nbusy), 32'(16));
    check("settle3 done", 32'(done_b), 32'(1));
    check("settle3 busy_end", 32'(busy_b), 32'(0));
    check("settle3 pass", 32'(pass_b), 32'(1));
    check("settle3 err", 32'(err_b), 32'(0));
    start_b = 1'b1;
    next_cycle();
    start_b = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("settle3 no restart busy %0d", k), 32'(busy_b), 32'(0));
      check($sformatf("settle3 no restart done %0d", k), 32'(done_b), 32'(0));
      check($sformatf("settle3 stable pass %0d", k), 32'(pass_b), 32'(1));
      check($sformatf("settle3 stable stim %0d", k), 32'(stim_b), 32'(3));
      next_cycle();
    end

    // Asynchronous reset at pattern 2 aborts the sweep
    op_a = 2'd0; use_real = 1'b0; tt = 4'h0;
    start_a = 1'b1;
    next_cycle();
    start_a = 1'b0;
    for (int i = 0; i < 20 && stim_a != 2'd2; i++) next_cycle();
    check("abort reached pat2", 32'(stim_a), 32'(2));
    #2;
    rstn = 1'b0;
    #1;
    check("abort stim", 32'(stim_a), 32'(0));
    check("abort busy", 32'(busy_a), 32'(0));
    check("abort err", 32'(err_a), 32'(0));
    check("abort ff", 32'(ff_a), 32'(0));
    check("abort pass", 32'(pass_a), 32'(0));
    check("abort done", 32'(done_a), 32'(0));
    next_cycle();
    next_cycle();
    rstn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("abort no done %0d", k), 32'(done_a | busy_a), 32'(0));
      next_cycle();
    end
    run_a(0, 1'b1, 4'h0, "post_reset");

    // Random ops and gate truth tables
    for (int it = 0; it < 12; it++) begin
      repeat ($urandom_range(0, 3)) next_cycle();
      run_a(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom),
            $sformatf("rnd%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
